// File: rtl/vector_stream_collector_pkg.sv
// Shared float constants for the vector
// collector and the summation datapath.
package vector_stream_collector_pkg;
  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_ZERO =
    32'h0000_0000;
endpackage

// File: rtl/vector_stream_collector_if.sv
// Element stream in, packed vector out,
// each with its own valid/ready handshake.
interface vector_stream_collector_if #(
  parameter int VLEN = 4,
  parameter int CW   = 3
);
  logic [31:0]        in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [32*VLEN-1:0] vec_data;
  logic               vec_valid;
  logic               vec_ready;
  logic [CW-1:0]      vec_count;

  modport master (
    output in_data, in_valid, in_last,
    output vec_ready,
    input  in_ready, vec_data,
    input  vec_valid, vec_count
  );

  modport slave (
    input  in_data, in_valid, in_last,
    input  vec_ready,
    output in_ready, vec_data,
    output vec_valid, vec_count
  );
endinterface

// File: rtl/vector_stream_collector.sv
// Packs one float per cycle into a VLEN-lane
// vector and holds it until consumed.
module vector_stream_collector
  import vector_stream_collector_pkg::*;
#(
  parameter int VLEN = 4,
  parameter int CW   = 3
) (
  input logic clk,
  input logic rst,
  vector_stream_collector_if.slave bus
);
  typedef enum logic {
    FILL,
    FULL
  } state_e;

  localparam logic [CW-1:0] LAST =
    CW'(VLEN - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] vec_count_q;
  logic          vec_valid_q;

  logic                in_xfer;
  logic                out_xfer;
  logic                close;
  logic [VLEN-1:0]     lane_we;
  logic [FP_WIDTH-1:0] lane_d [VLEN];

  assign bus.in_ready = !rst &&
    (state_q == FILL || bus.vec_ready);
  assign in_xfer  = bus.in_valid
                  & bus.in_ready;
  assign out_xfer = vec_valid_q
                  & bus.vec_ready;
  assign close    = (cnt_q == LAST)
                  | bus.in_last;

  assign bus.vec_valid = vec_valid_q;
  assign bus.vec_count = vec_count_q;

  // Lane write enables: fill slot, zero the
  // tail on close, wipe all on hand-off.
  always_comb begin
    for (int k = 0; k < VLEN; k++) begin
      lane_we[k] = 1'b0;
      lane_d[k]  = FP_ZERO;
      if (state_q == FILL && in_xfer) begin
        if (CW'(k) == cnt_q) begin
          lane_we[k] = 1'b1;
          lane_d[k]  = bus.in_data;
        end else if (close &&
                     CW'(k) > cnt_q) begin
          lane_we[k] = 1'b1;
        end
      end else if (state_q == FULL &&
                   out_xfer) begin
        lane_we[k] = 1'b1;
        if (k == 0 && in_xfer)
          lane_d[k] = bus.in_data;
      end
    end
  end

  for (genvar k = 0; k < VLEN; k++)
  begin : g_lane
    logic [FP_WIDTH-1:0] q;

    // Enabled 32-bit lane register.
    always_ff @(posedge clk) begin
      if (rst)             q <= FP_ZERO;
      else if (lane_we[k]) q <= lane_d[k];
    end

    assign bus.vec_data[FP_WIDTH*k +:
                        FP_WIDTH] = q;
  end

  // Fill/hold sequencing with registered
  // vec_valid and vec_count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      vec_valid_q <= 1'b0;
      vec_count_q <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_xfer) begin
            if (close) begin
              state_q     <= FULL;
              vec_valid_q <= 1'b1;
              vec_count_q <= cnt_q + ONE;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
        end
        FULL: begin
          if (out_xfer) begin
            if (in_xfer) begin
              if (VLEN == 1 ||
                  bus.in_last) begin
                vec_count_q <= ONE;
              end else begin
                state_q     <= FILL;
                vec_valid_q <= 1'b0;
                cnt_q       <= ONE;
              end
            end else begin
              state_q     <= FILL;
              vec_valid_q <= 1'b0;
              cnt_q       <= '0;
            end
          end
        end
        default: begin
          state_q     <= FILL;
          vec_valid_q <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vector_stream_collector.sv
// Directed table bench for the collector,
// plus reset and VLEN=1 sequences.
module tb_vector_stream_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_stream_collector_if
    #(.VLEN(4), .CW(3)) b4 ();
  vector_stream_collector_if
    #(.VLEN(1), .CW(1)) b1 ();

  vector_stream_collector
    #(.VLEN(4), .CW(3)) u4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );
  vector_stream_collector
    #(.VLEN(1), .CW(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  typedef struct {
    logic [31:0]  d;
    logic         v;
    logic         l;
    logic         vr;
    logic         e_rdy;
    logic         e_vv;
    logic [127:0] e_data;
    logic [2:0]   e_cnt;
  } row_t;

  row_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic add(
    input logic [31:0] d, input logic v,
    input logic l, input logic vr,
    input logic rdy, input logic vv,
    input logic [127:0] dat,
    input logic [2:0] cnt);
    row_t r;
    r.d = d; r.v = v; r.l = l; r.vr = vr;
    r.e_rdy = rdy; r.e_vv = vv;
    r.e_data = dat; r.e_cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic drv4(input logic [31:0] d,
                      input logic v,
                      input logic l,
                      input logic vr);
    b4.in_data = d; b4.in_valid = v;
    b4.in_last = l; b4.vec_ready = vr;
  endtask

  localparam logic [127:0] Z = '0;
  logic [31:0] e1 [6];
  int nvv;

  initial begin
    drv4(32'h0, 1'b1, 1'b0, 1'b1);
    b1.in_data = '0; b1.in_valid = 1'b0;
    b1.in_last = 1'b0; b1.vec_ready = 1'b1;

    // full vector
    add(32'h3F800000,1,0,1, 1,0,Z,0);
    add(32'h40000000,1,0,1, 1,0,Z,0);
    add(32'h40400000,1,0,1, 1,0,Z,0);
    add(32'h40800000,1,0,1, 1,0,Z,0);
    add(32'h0,0,0,1, 1,1,
      {32'h40800000,32'h40400000,
       32'h40000000,32'h3F800000},4);
    // short vector
    add(32'h3F800000,1,0,1, 1,0,Z,0);
    add(32'h40000000,1,1,1, 1,0,Z,0);
    add(32'h0,0,0,0, 0,1,
      {64'h0,32'h40000000,32'h3F800000},2);
    add(32'h0,0,0,1, 1,1,
      {64'h0,32'h40000000,32'h3F800000},2);
    // back-to-back 1.0..8.0
    add(32'h3F800000,1,0,1, 1,0,Z,0);
    add(32'h40000000,1,0,1, 1,0,Z,0);
    add(32'h40400000,1,0,1, 1,0,Z,0);
    add(32'h40800000,1,0,1, 1,0,Z,0);
    add(32'h40A00000,1,0,1, 1,1,
      {32'h40800000,32'h40400000,
       32'h40000000,32'h3F800000},4);
    add(32'h40C00000,1,0,1, 1,0,Z,0);
    add(32'h40E00000,1,0,1, 1,0,Z,0);
    add(32'h41000000,1,0,1, 1,0,Z,0);
    // backpressure with 5th element held
    for (int i = 0; i < 5; i++)
      add(32'h40A00000,1,0,0, 0,1,
        {32'h41000000,32'h40E00000,
         32'h40C00000,32'h40A00000},4);
    add(32'h40A00000,1,0,1, 1,1,
      {32'h41000000,32'h40E00000,
       32'h40C00000,32'h40A00000},4);
    add(32'h0,0,0,1, 1,0,Z,0);
    // NaN closes a 2-lane vector
    add(32'hFFC00000,1,1,1, 1,0,Z,0);
    add(32'h0,0,0,1, 1,1,
      {64'h0,32'hFFC00000,32'h40A00000},2);
    // -0.0 alone, then Inf with last
    // during hand-off: stays FULL
    add(32'h80000000,1,1,1, 1,0,Z,0);
    add(32'h7F800000,1,1,1, 1,1,
      {96'h0,32'h80000000},1);
    add(32'h0,0,0,1, 1,1,
      {96'h0,32'h7F800000},1);
    add(32'h0,0,0,1, 1,0,Z,0);
    // redundant in_last on lane 3
    add(32'h11111111,1,0,1, 1,0,Z,0);
    add(32'h22222222,1,0,1, 1,0,Z,0);
    add(32'h33333333,1,0,1, 1,0,Z,0);
    add(32'h44444444,1,1,1, 1,0,Z,0);
    add(32'h0,0,0,1, 1,1,
      {32'h44444444,32'h33333333,
       32'h22222222,32'h11111111},4);
    add(32'h0,0,0,1, 1,0,Z,0);

    // reset state
    @(negedge clk); #1;
    chk("rst_in_ready", 128'(b4.in_ready), 0);
    chk("rst_vec_valid",128'(b4.vec_valid),0);
    chk("rst_vec_data", b4.vec_data, Z);
    chk("rst_vec_count",128'(b4.vec_count),0);
    chk("rst_vv1", 128'(b1.vec_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    drv4(32'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      drv4(tbl[i].d, tbl[i].v,
           tbl[i].l, tbl[i].vr);
      #1;
      chk($sformatf("row%0d_in_ready", i),
          128'(b4.in_ready),
          128'(tbl[i].e_rdy));
      chk($sformatf("row%0d_vec_valid", i),
          128'(b4.vec_valid),
          128'(tbl[i].e_vv));
      if (tbl[i].e_vv) begin
        chk($sformatf("row%0d_data", i),
            b4.vec_data, tbl[i].e_data);
        chk($sformatf("row%0d_count", i),
            128'(b4.vec_count),
            128'(tbl[i].e_cnt));
      end
      @(negedge clk);
    end

    // reset mid-fill discards the partial
    drv4(32'hAAAA0001, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drv4(32'hAAAA0002, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drv4(32'h0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready",
        128'(b4.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    nvv = 0;
    for (int i = 0; i < 8; i++) begin
      drv4(32'h40800000, i < 4, 1'b0, 1'b1);
      #1;
      if (b4.vec_valid) begin
        nvv++;
        chk("midrst_data", b4.vec_data,
            {4{32'h40800000}});
        chk("midrst_count",
            128'(b4.vec_count), 4);
      end
      @(negedge clk);
    end
    chk("midrst_nvec", 128'(nvv), 1);
    drv4(32'h0, 1'b0, 1'b0, 1'b1);

    // VLEN=1: one-cycle-late pass-through
    e1[0] = 32'h3F800000; e1[1] = 32'h80000000;
    e1[2] = 32'h7FC00001; e1[3] = 32'h40000000;
    e1[4] = 32'hFF800000; e1[5] = 32'h12345678;
    for (int j = 0; j <= 6; j++) begin
      b1.in_data  = (j < 6) ? e1[j] : 32'h0;
      b1.in_valid = (j < 6);
      #1;
      chk($sformatf("v1_vv%0d", j),
          128'(b1.vec_valid),
          128'(j > 0));
      chk($sformatf("v1_rdy%0d", j),
          128'(b1.in_ready), 1);
      if (j > 0) begin
        chk($sformatf("v1_data%0d", j),
            128'(b1.vec_data),
            128'(e1[j-1]));
        chk($sformatf("v1_cnt%0d", j),
            128'(b1.vec_count), 1);
      end
      @(negedge clk);
    end
    #1;
    chk("v1_drain", 128'(b1.vec_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
